// File: rtl/lock_pkg.sv
// Shared definitions for the gondola lock: FSM state codes, travel direction
// and the default timing/level constants.
package lock_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        APPROACH = 3'd1,
        ARRIVED  = 3'd2,
        ENTER    = 3'd3,
        IN_POUND = 3'd4,
        DEPART   = 3'd5
    } lock_state_t;

    localparam logic DIR_OUT2IN = 1'b0;
    localparam logic DIR_IN2OUT = 1'b1;

    localparam int DEF_ARRIVE_TICKS = 10;
    localparam int DEF_DOOR_TICKS   = 4;
    localparam int DEF_DEPART_TICKS = 10;
    localparam int DEF_LEVEL_MAX    = 8;
    localparam int DEF_LEVEL_W      = 4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lock_edge_detect.sv
// Registers one switch input and produces a single-cycle pulse on its rising edge,
// so a held switch yields exactly one pulse.
module lock_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic sw,
    output logic rise
);

    logic sw_q;
    logic sw_qq;

    always_ff @(posedge clk) begin
        if (reset) begin
            sw_q  <= 1'b0;
            sw_qq <= 1'b0;
        end else begin
            sw_q  <= sw;
            sw_qq <= sw_q;
        end
    end

    assign rise = sw_q & ~sw_qq;

endmodule

// File: rtl/gondola_lock_controller.sv
// Sequences one gondola at a time through the pound (approach, entry door, level
// change, exit door, departure) and drives the side LEDs, level and state display.
module gondola_lock_controller
    import lock_pkg::*;
#(
    parameter int ARRIVE_TICKS = DEF_ARRIVE_TICKS,
    parameter int DOOR_TICKS   = DEF_DOOR_TICKS,
    parameter int DEPART_TICKS = DEF_DEPART_TICKS,
    parameter int LEVEL_MAX    = DEF_LEVEL_MAX,
    parameter int LEVEL_W      = DEF_LEVEL_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               outer_gondola_arrival_sw,
    input  logic               inner_gondola_arrival_sw,
    input  logic               outer_door_sw,
    input  logic               inner_door_sw,
    input  logic               inc_water_level,
    input  logic               dec_water_level,
    output logic               outer_gondola_led,
    output logic               inner_gondola_led,
    output logic               outer_door_openable_led,
    output logic               inner_door_openable_led,
    output logic               outer_door_open,
    output logic               inner_door_open,
    output logic [LEVEL_W-1:0] water_level,
    output logic [2:0]         state_code,
    output logic               pending
);

    localparam int CNT_MAX = max3(ARRIVE_TICKS, DOOR_TICKS, DEPART_TICKS);
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]   ARRIVE_LOAD = CNT_W'(ARRIVE_TICKS - 1);
    localparam logic [CNT_W-1:0]   DOOR_LOAD   = CNT_W'(DOOR_TICKS - 1);
    localparam logic [CNT_W-1:0]   DEPART_LOAD = CNT_W'(DEPART_TICKS - 1);
    localparam logic [LEVEL_W-1:0] LEVEL_TOP   = LEVEL_W'(LEVEL_MAX);

    logic outer_arr_edge, inner_arr_edge;
    logic outer_door_edge, inner_door_edge;
    logic inc_edge, dec_edge;

    lock_edge_detect u_outer_arr  (.clk(clk), .reset(reset), .sw(outer_gondola_arrival_sw), .rise(outer_arr_edge));
    lock_edge_detect u_inner_arr  (.clk(clk), .reset(reset), .sw(inner_gondola_arrival_sw), .rise(inner_arr_edge));
    lock_edge_detect u_outer_door (.clk(clk), .reset(reset), .sw(outer_door_sw),            .rise(outer_door_edge));
    lock_edge_detect u_inner_door (.clk(clk), .reset(reset), .sw(inner_door_sw),            .rise(inner_door_edge));
    lock_edge_detect u_inc        (.clk(clk), .reset(reset), .sw(inc_water_level),          .rise(inc_edge));
    lock_edge_detect u_dec        (.clk(clk), .reset(reset), .sw(dec_water_level),          .rise(dec_edge));

    lock_state_t        state_q, state_next;
    logic               dir_q, dir_next;
    logic               pending_q, pending_next;
    logic               pending_dir_q, pending_dir_next;
    logic [CNT_W-1:0]   cnt_q, cnt_next;
    logic [LEVEL_W-1:0] level_q, level_next;

    logic               entry_led, exit_led;
    logic               entry_openable, exit_openable;
    logic               entry_open, exit_open;
    logic [LEVEL_W-1:0] entry_level, exit_level;
    logic               entry_door_edge, exit_door_edge, opposite_arr_edge;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            dir_q         <= DIR_OUT2IN;
            pending_q     <= 1'b0;
            pending_dir_q <= DIR_OUT2IN;
            cnt_q         <= '0;
            level_q       <= '0;
        end else begin
            state_q       <= state_next;
            dir_q         <= dir_next;
            pending_q     <= pending_next;
            pending_dir_q <= pending_dir_next;
            cnt_q         <= cnt_next;
            level_q       <= level_next;
        end
    end

    // Everything is expressed relative to the entry/exit side, then mapped to outer/inner.
    always_comb begin
        state_next       = state_q;
        dir_next         = dir_q;
        pending_next     = pending_q;
        pending_dir_next = pending_dir_q;
        cnt_next         = cnt_q;
        level_next       = level_q;
        entry_led        = 1'b0;
        exit_led         = 1'b0;
        entry_openable   = 1'b0;
        exit_openable    = 1'b0;
        entry_open       = 1'b0;
        exit_open        = 1'b0;

        entry_level       = (dir_q == DIR_OUT2IN) ? '0 : LEVEL_TOP;
        exit_level        = (dir_q == DIR_OUT2IN) ? LEVEL_TOP : '0;
        entry_door_edge   = (dir_q == DIR_OUT2IN) ? outer_door_edge : inner_door_edge;
        exit_door_edge    = (dir_q == DIR_OUT2IN) ? inner_door_edge : outer_door_edge;
        opposite_arr_edge = (dir_q == DIR_OUT2IN) ? inner_arr_edge : outer_arr_edge;

        case (state_q)
            IDLE: begin
                if (outer_arr_edge) begin
                    state_next = APPROACH;
                    dir_next   = DIR_OUT2IN;
                    cnt_next   = ARRIVE_LOAD;
                    if (inner_arr_edge) begin
                        pending_next     = 1'b1;
                        pending_dir_next = DIR_IN2OUT;
                    end else if (pending_q && pending_dir_q == DIR_OUT2IN) begin
                        pending_next = 1'b0;
                    end
                end else if (inner_arr_edge) begin
                    state_next = APPROACH;
                    dir_next   = DIR_IN2OUT;
                    cnt_next   = ARRIVE_LOAD;
                    if (pending_q && pending_dir_q == DIR_IN2OUT) begin
                        pending_next = 1'b0;
                    end
                end else if (pending_q) begin
                    state_next   = APPROACH;
                    dir_next     = pending_dir_q;
                    cnt_next     = ARRIVE_LOAD;
                    pending_next = 1'b0;
                end
            end
            APPROACH: begin
                entry_led = 1'b1;
                if (cnt_q == '0) begin
                    state_next = ARRIVED;
                end else begin
                    cnt_next = cnt_q - 1'b1;
                end
            end
            ARRIVED: begin
                entry_led      = 1'b1;
                entry_openable = (level_q == entry_level);
                if (entry_door_edge && entry_openable) begin
                    state_next = ENTER;
                    cnt_next   = DOOR_LOAD;
                end
            end
            ENTER: begin
                entry_open = 1'b1;
                if (cnt_q == '0) begin
                    state_next = IN_POUND;
                end else begin
                    cnt_next = cnt_q - 1'b1;
                end
            end
            IN_POUND: begin
                exit_openable = (level_q == exit_level);
                if (exit_door_edge && exit_openable) begin
                    state_next = DEPART;
                    cnt_next   = DEPART_LOAD;
                end
            end
            DEPART: begin
                exit_open = 1'b1;
                exit_led  = 1'b1;
                if (cnt_q == '0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_q - 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A request from the far side is remembered once; the active side's own requests are dropped.
        if (state_q != IDLE && opposite_arr_edge && !pending_q) begin
            pending_next     = 1'b1;
            pending_dir_next = ~dir_q;
        end

        if (state_q != ENTER && state_q != DEPART) begin
            if (inc_edge && !dec_edge && level_q != LEVEL_TOP) begin
                level_next = level_q + 1'b1;
            end else if (dec_edge && !inc_edge && level_q != '0) begin
                level_next = level_q - 1'b1;
            end
        end
    end

    assign outer_gondola_led       = (dir_q == DIR_OUT2IN) ? entry_led      : exit_led;
    assign inner_gondola_led       = (dir_q == DIR_OUT2IN) ? exit_led       : entry_led;
    assign outer_door_openable_led = (dir_q == DIR_OUT2IN) ? entry_openable : exit_openable;
    assign inner_door_openable_led = (dir_q == DIR_OUT2IN) ? exit_openable  : entry_openable;
    assign outer_door_open         = (dir_q == DIR_OUT2IN) ? entry_open     : exit_open;
    assign inner_door_open         = (dir_q == DIR_OUT2IN) ? exit_open      : entry_open;
    assign water_level             = level_q;
    assign state_code              = state_q;
    assign pending                 = pending_q;

endmodule

// File: tb/tb_gondola_lock_controller.sv
// Scoreboard bench for gondola_lock_controller: directed transits followed by random
// switch activity, each cycle checked against a behavioural model of the lock rules.
module tb_gondola_lock_controller;

    localparam int ARRIVE = 10;
    localparam int DOOR   = 4;
    localparam int DEPART = 10;
    localparam int LMAX   = 8;

    localparam logic [6:0] RST = 7'b1000000;
    localparam logic [6:0] OA  = 7'b0100000;
    localparam logic [6:0] IA  = 7'b0010000;
    localparam logic [6:0] OD  = 7'b0001000;
    localparam logic [6:0] ID  = 7'b0000100;
    localparam logic [6:0] INC = 7'b0000010;
    localparam logic [6:0] DEC = 7'b0000001;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       oa_sw = 1'b0, ia_sw = 1'b0, od_sw = 1'b0, id_sw = 1'b0, inc_sw = 1'b0, dec_sw = 1'b0;
    logic       outer_gondola_led, inner_gondola_led;
    logic       outer_door_openable_led, inner_door_openable_led;
    logic       outer_door_open, inner_door_open;
    logic [3:0] water_level;
    logic [2:0] state_code;
    logic       pending;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;
    logic [13:0] exp_q[$];

    // Behavioural model: phase number, cycles spent in it, travel side and pound level.
    int   m_phase, m_time, m_from_inner, m_pend, m_pend_inner, m_level;
    logic [5:0] hist1, hist2;

    always #5 clk = ~clk;

    gondola_lock_controller #(
        .ARRIVE_TICKS(ARRIVE), .DOOR_TICKS(DOOR), .DEPART_TICKS(DEPART),
        .LEVEL_MAX(LMAX), .LEVEL_W(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .outer_gondola_arrival_sw(oa_sw),
        .inner_gondola_arrival_sw(ia_sw),
        .outer_door_sw(od_sw),
        .inner_door_sw(id_sw),
        .inc_water_level(inc_sw),
        .dec_water_level(dec_sw),
        .outer_gondola_led(outer_gondola_led),
        .inner_gondola_led(inner_gondola_led),
        .outer_door_openable_led(outer_door_openable_led),
        .inner_door_openable_led(inner_door_openable_led),
        .outer_door_open(outer_door_open),
        .inner_door_open(inner_door_open),
        .water_level(water_level),
        .state_code(state_code),
        .pending(pending)
    );

    function automatic logic [13:0] model_outputs();
        logic side_inner;
        logic o_led, i_led, o_opn, i_opn, o_open, i_open;
        int   here_level, far_level;
        side_inner = (m_from_inner != 0);
        here_level = side_inner ? LMAX : 0;
        far_level  = side_inner ? 0 : LMAX;
        o_led = 0; i_led = 0; o_opn = 0; i_opn = 0; o_open = 0; i_open = 0;
        if (m_phase == 1 || m_phase == 2) begin
            if (side_inner) i_led = 1; else o_led = 1;
        end
        if (m_phase == 2 && m_level == here_level) begin
            if (side_inner) i_opn = 1; else o_opn = 1;
        end
        if (m_phase == 3) begin
            if (side_inner) i_open = 1; else o_open = 1;
        end
        if (m_phase == 4 && m_level == far_level) begin
            if (side_inner) o_opn = 1; else i_opn = 1;
        end
        if (m_phase == 5) begin
            if (side_inner) begin o_open = 1; o_led = 1; end
            else begin i_open = 1; i_led = 1; end
        end
        return {o_led, i_led, o_opn, i_opn, o_open, i_open, 4'(m_level), 3'(m_phase), (m_pend != 0)};
    endfunction

    task automatic model_step(input logic [6:0] v);
        logic [5:0] e;
        logic oa, ia, od, idr, inc, dec;
        int   old_level, next_phase;
        if (v[6]) begin
            m_phase = 0; m_time = 0; m_from_inner = 0; m_pend = 0; m_pend_inner = 0; m_level = 0;
            hist1 = '0; hist2 = '0;
            return;
        end
        e = hist1 & ~hist2;
        {oa, ia, od, idr, inc, dec} = e;
        old_level  = m_level;
        next_phase = m_phase;
        case (m_phase)
            0: begin
                if (oa) begin
                    next_phase = 1; m_from_inner = 0;
                    if (ia) begin m_pend = 1; m_pend_inner = 1; end
                    else if (m_pend != 0 && m_pend_inner == 0) m_pend = 0;
                end else if (ia) begin
                    next_phase = 1; m_from_inner = 1;
                    if (m_pend != 0 && m_pend_inner == 1) m_pend = 0;
                end else if (m_pend != 0) begin
                    next_phase = 1; m_from_inner = m_pend_inner; m_pend = 0;
                end
            end
            1: begin m_time++; if (m_time == ARRIVE) next_phase = 2; end
            2: if ((m_from_inner ? idr : od) && old_level == (m_from_inner ? LMAX : 0)) next_phase = 3;
            3: begin m_time++; if (m_time == DOOR) next_phase = 4; end
            4: if ((m_from_inner ? od : idr) && old_level == (m_from_inner ? 0 : LMAX)) next_phase = 5;
            default: begin m_time++; if (m_time == DEPART) next_phase = 0; end
        endcase
        if (m_phase != 0 && (m_from_inner ? oa : ia) && m_pend == 0) begin
            m_pend = 1; m_pend_inner = 1 - m_from_inner;
        end
        if (m_phase != 3 && m_phase != 5) begin
            if (inc && !dec && old_level < LMAX) m_level = old_level + 1;
            if (dec && !inc && old_level > 0)    m_level = old_level - 1;
        end
        if (next_phase != m_phase) m_time = 0;
        m_phase = next_phase;
        hist2 = hist1;
        hist1 = v[5:0];
    endtask

    task automatic apply_stimulus(input logic [6:0] v);
        @(negedge clk);
        {reset, oa_sw, ia_sw, od_sw, id_sw, inc_sw, dec_sw} = v;
        @(posedge clk);
        model_step(v);
        exp_q.push_back(model_outputs());
    endtask

    task automatic pulse(input logic [6:0] v);
        apply_stimulus(v);
        apply_stimulus(7'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(7'b0);
    endtask

    task automatic check_output(input logic [13:0] expv);
        logic [13:0] got;
        got = {outer_gondola_led, inner_gondola_led, outer_door_openable_led, inner_door_openable_led,
               outer_door_open, inner_door_open, water_level, state_code, pending};
        checks++;
        if (got !== expv) begin
            errors++;
            $display("[TB] FAIL outputs cycle=%0d got=%b required=%b (leds,openable,open,level,state,pending)",
                     cycle, got, expv);
        end
    endtask

    // Monitor: compares one expected vector per clock, just after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (exp_q.size() != 0) check_output(exp_q.pop_front());
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog timeout at cycle %0d", cycle);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [6:0] v;
        m_phase = 0; m_time = 0; m_from_inner = 0; m_pend = 0; m_pend_inner = 0; m_level = 0;
        hist1 = '0; hist2 = '0;

        apply_stimulus(RST);
        apply_stimulus(RST);
        idle(2);

        // Outer-to-inner transit
        pulse(OA); idle(12); pulse(OD); idle(6);
        repeat (8) pulse(INC);
        idle(2); pulse(ID); idle(12);

        // Inner-to-outer transit at level 8
        pulse(IA); idle(12); pulse(ID); idle(6);
        repeat (8) pulse(DEC);
        idle(2); pulse(OD); idle(12);

        // Wrong doors, then saturation inside the pound
        pulse(OA); idle(3); pulse(OD); idle(10); pulse(ID); idle(3);
        pulse(OD); idle(6);
        pulse(DEC); idle(2);
        repeat (12) pulse(INC);
        idle(2); pulse(ID); idle(12);
        repeat (5) pulse(DEC);
        pulse(INC | DEC); idle(3);
        repeat (3) pulse(DEC);
        idle(2);

        // Simultaneous arrivals, a dropped second inner request, then the pending one served
        pulse(OA | IA); idle(6); pulse(IA); idle(8); pulse(OD); idle(6);
        repeat (8) pulse(INC);
        idle(2); pulse(ID); idle(14);
        idle(12); pulse(ID); idle(6);
        repeat (8) pulse(DEC);
        pulse(OD); idle(12);

        // Reset while the outer door is open
        pulse(OA); idle(12); pulse(OD); idle(2);
        apply_stimulus(RST); idle(4);

        // Random switch activity
        v = 7'b0;
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 6; b++) begin
                if ($urandom_range(0, 5) == 0) v[b] = ~v[b];
            end
            v[6] = ($urandom_range(0, 599) == 0);
            apply_stimulus(v);
        end
        idle(4);

        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain leftover=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
